// File: rtl/param_arbiter.sv
// Response-channel arbiter: command bursts first, involuntary bursts round-robin, registered output mux.
// Optional statistics outputs are built when PARAM_ARB_STATS_EN is defined.
module param_arbiter #(
  parameter int N_UNITS       = 4,
  parameter int GRANT_TIMEOUT = 255,
  localparam int UB           = (N_UNITS > 2) ? $clog2(N_UNITS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_active,
  input  logic [UB-1:0]          cmd_unit,
  input  logic [N_UNITS-1:0]     invol_req,
  output logic [N_UNITS-1:0]     invol_grant,
  input  logic [32*N_UNITS-1:0]  unit_data,
  input  logic [N_UNITS-1:0]     unit_write,
  input  logic                   out_full,
  output logic [31:0]            out_data,
  output logic                   out_write,
  output logic                   out_end,
  output logic                   timeout_err,
  output logic [1:0]             dbg_state
`ifdef PARAM_ARB_STATS_EN
  ,
  output logic [31:0]            stat_bursts,
  output logic [15:0]            stat_timeouts
`endif
);

  // Burst handshake: a source holds write high with one word per cycle; the first cycle
  // with write low carries the response code and becomes a single out_end cycle downstream.
  typedef enum logic [1:0] {S_IDLE, S_CMD, S_GRANT, S_BURST} state_t;

  localparam logic [UB:0]          N_EXT  = N_UNITS[UB:0];
  localparam logic [8:0]           TO_LIM = 9'(GRANT_TIMEOUT);
  localparam bit                   TO_EN  = (GRANT_TIMEOUT != 0);
  localparam logic [N_UNITS-1:0]   ONE    = 1;

  state_t        state;
  logic [UB-1:0] owner;
  logic [UB-1:0] rr_ptr;
  logic [UB-1:0] pick;
  logic          pick_found;
  logic          seen;
  logic [7:0]    wait_cnt;
  logic          src_write;
  logic [31:0]   src_data;
  logic [UB:0]   cmd_ext;
  logic          cmd_ok;
  logic          timeout_hit;

  assign cmd_ext     = {1'b0, cmd_unit};
  assign cmd_ok      = (cmd_ext < N_EXT);
  assign timeout_hit = TO_EN && (({1'b0, wait_cnt} + 9'd1) == TO_LIM);
  assign dbg_state   = state;

  always_comb begin
    src_write = 1'b0;
    src_data  = '0;
    for (int i = 0; i < N_UNITS; i++) begin
      if (owner == UB'(i)) begin
        src_write = unit_write[i];
        src_data  = unit_data[32*i +: 32];
      end
    end
  end

  // Search starts just after the last granted unit so every requester is reached in turn.
  always_comb begin
    pick_found = 1'b0;
    pick       = '0;
    for (int k = 1; k <= N_UNITS; k++) begin
      if (!pick_found && invol_req[(int'(rr_ptr) + k) % N_UNITS]) begin
        pick_found = 1'b1;
        pick       = UB'((int'(rr_ptr) + k) % N_UNITS);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      owner       <= '0;
      rr_ptr      <= UB'(N_UNITS - 1);
      seen        <= 1'b0;
      wait_cnt    <= '0;
      invol_grant <= '0;
      out_data    <= '0;
      out_write   <= 1'b0;
      out_end     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      out_data    <= '0;
      out_write   <= 1'b0;
      out_end     <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!out_full) begin
            if (cmd_active) begin
              if (cmd_ok) begin
                owner <= cmd_unit;
                seen  <= 1'b0;
                state <= S_CMD;
              end else begin
                timeout_err <= 1'b1;
              end
            end else if (pick_found) begin
              owner       <= pick;
              rr_ptr      <= pick;
              invol_grant <= ONE << pick;
              wait_cnt    <= '0;
              state       <= S_GRANT;
            end
          end
        end
        S_CMD: begin
          if (src_write) begin
            out_data  <= src_data;
            out_write <= 1'b1;
            seen      <= 1'b1;
          end else if (seen) begin
            out_data <= src_data;
            out_end  <= 1'b1;
            state    <= S_IDLE;
          end else if (!cmd_active) begin
            state <= S_IDLE;
          end
        end
        S_GRANT: begin
          if (src_write) begin
            out_data  <= src_data;
            out_write <= 1'b1;
            state     <= S_BURST;
          end else if (timeout_hit) begin
            invol_grant <= '0;
            timeout_err <= 1'b1;
            state       <= S_IDLE;
          end else if (wait_cnt != 8'hFF) begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_BURST: begin
          if (src_write) begin
            out_data  <= src_data;
            out_write <= 1'b1;
          end else begin
            out_data    <= src_data;
            out_end     <= 1'b1;
            invol_grant <= '0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef PARAM_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_bursts   <= '0;
      stat_timeouts <= '0;
    end else begin
      if (out_end)
        stat_bursts <= stat_bursts + 32'd1;
      if (timeout_err && stat_timeouts != 16'hFFFF)
        stat_timeouts <= stat_timeouts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_param_arbiter.sv
// Bench for param_arbiter: directed scenarios plus random traffic against a burst-level model.
module tb_param_arbiter;
  localparam int N  = 4;
  localparam int TO = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           cmd_active;
  logic [1:0]     cmd_unit;
  logic [N-1:0]   invol_req;
  logic [N-1:0]   invol_grant;
  logic [32*N-1:0] unit_data;
  logic [N-1:0]   unit_write;
  logic           out_full;
  logic [31:0]    out_data;
  logic           out_write;
  logic           out_end;
  logic           timeout_err;
  logic [1:0]     dbg_state;
`ifdef PARAM_ARB_STATS_EN
  logic [31:0]    stat_bursts;
  logic [15:0]    stat_timeouts;
`endif

  param_arbiter #(.N_UNITS(N), .GRANT_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .cmd_active(cmd_active), .cmd_unit(cmd_unit),
    .invol_req(invol_req), .invol_grant(invol_grant), .unit_data(unit_data),
    .unit_write(unit_write), .out_full(out_full), .out_data(out_data),
    .out_write(out_write), .out_end(out_end), .timeout_err(timeout_err),
    .dbg_state(dbg_state)
`ifdef PARAM_ARB_STATS_EN
    , .stat_bursts(stat_bursts), .stat_timeouts(stat_timeouts)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Burst-level model: who owns the channel, how many words it has sent, how long it waited.
  int          m_owner;
  bit          m_is_cmd;
  int          m_words;
  int          m_wait;
  int          m_ptr;
  int          m_bursts;
  int          m_touts;
  bit          prev_end;
  bit          prev_to;
  logic [N-1:0] e_grant;
  logic        e_write, e_end, e_to;
  logic [31:0] e_data;

  task automatic model_step();
    logic        w;
    logic [31:0] d;
    if (rst) begin
      m_owner = -1; m_is_cmd = 0; m_words = 0; m_wait = 0; m_ptr = N - 1;
      m_bursts = 0; m_touts = 0; prev_end = 0; prev_to = 0;
      e_grant = '0; e_write = 0; e_end = 0; e_to = 0; e_data = '0;
      return;
    end
    m_bursts += int'(prev_end);
    if (prev_to && m_touts != 65535) m_touts++;
    e_write = 0; e_end = 0; e_to = 0; e_data = '0;
    if (m_owner < 0) begin
      if (!out_full) begin
        if (cmd_active) begin
          if (int'(cmd_unit) < N) begin
            m_owner = int'(cmd_unit); m_is_cmd = 1; m_words = 0;
          end else begin
            e_to = 1;
          end
        end else if (invol_req != '0) begin
          for (int k = 1; k <= N; k++) begin
            if (invol_req[(m_ptr + k) % N]) begin
              m_owner = (m_ptr + k) % N;
              break;
            end
          end
          m_ptr = m_owner; m_is_cmd = 0; m_words = 0; m_wait = 0;
          e_grant = '0; e_grant[m_owner] = 1'b1;
        end
      end
    end else begin
      w = unit_write[m_owner];
      d = unit_data[32*m_owner +: 32];
      if (w) begin
        e_write = 1; e_data = d; m_words++;
      end else if (m_words > 0) begin
        e_end = 1; e_data = d; m_owner = -1; e_grant = '0;
      end else if (m_is_cmd) begin
        if (!cmd_active) m_owner = -1;
      end else begin
        m_wait++;
        if (m_wait == TO) begin
          e_to = 1; m_owner = -1; e_grant = '0;
        end
      end
    end
    prev_end = e_end;
    prev_to  = e_to;
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    chk("grant", 32'(invol_grant), 32'(e_grant));
    chk("write", 32'(out_write), 32'(e_write));
    chk("end", 32'(out_end), 32'(e_end));
    chk("timeout_err", 32'(timeout_err), 32'(e_to));
    if (e_write || e_end) chk("data", out_data, e_data);
`ifdef PARAM_ARB_STATS_EN
    chk("stat_bursts", stat_bursts, 32'(m_bursts));
    chk("stat_timeouts", 32'(stat_timeouts), 32'(m_touts));
`endif
  end

  task automatic wr(input int u, input logic w, input logic [31:0] d);
    unit_write[u] = w;
    unit_data[32*u +: 32] = d;
  endtask

  task automatic wait_grant(input logic [N-1:0] want, input string nm);
    for (int c = 0; c < 50 && invol_grant == '0; c++) @(negedge clk);
    chk(nm, 32'(invol_grant), 32'(want));
  endtask

  // One data word, then the response code; returns at the negedge after the end edge.
  task automatic do_burst(input int u, input logic [31:0] code, input string nm);
    wr(u, 1'b1, $urandom);
    @(negedge clk);
    wr(u, 1'b0, code);
    @(negedge clk);
    chk(nm, 32'(out_end), 32'd1);
    wr(u, 1'b0, '0);
  endtask

  initial begin
    int cnt;
    int order[5] = '{0, 1, 2, 3, 0};
    rst = 1'b1; cmd_active = 0; cmd_unit = '0; invol_req = '0;
    unit_data = '0; unit_write = '0; out_full = 0;
    repeat (3) @(negedge clk);
    chk("reset_out", {30'd0, out_write, out_end}, 32'd0);
    chk("reset_grant", 32'(invol_grant), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: command burst from unit 1
    cmd_active = 1; cmd_unit = 2'd1;
    @(negedge clk);
    wr(1, 1'b1, 32'h11);
    @(negedge clk);
    chk("t1_w0", out_data, 32'h11); chk("t1_wr0", 32'(out_write), 32'd1);
    wr(1, 1'b1, 32'h22);
    @(negedge clk);
    chk("t1_w1", out_data, 32'h22);
    wr(1, 1'b0, 32'h05);
    @(negedge clk);
    chk("t1_end", 32'(out_end), 32'd1); chk("t1_code", out_data, 32'h05);
    chk("t1_wr_low", 32'(out_write), 32'd0);
    cmd_active = 0; wr(1, 1'b0, '0);
    @(negedge clk);
    chk("t1_end_pulse", 32'(out_end), 32'd0);

    // 2: all units request, round-robin from unit 0
    invol_req = 4'hF;
    for (int i = 0; i < 5; i++) begin
      wait_grant(N'(1) << order[i], $sformatf("t2_grant%0d", i));
      do_burst(order[i], 32'hC0 + i, $sformatf("t2_end%0d", i));
      chk($sformatf("t2_drop%0d", i), 32'(invol_grant), 32'd0);
    end
    invol_req = '0;
    repeat (2) @(negedge clk);

    // 3: command wins over a simultaneous involuntary request
    invol_req = 4'b0100; cmd_active = 1; cmd_unit = 2'd0;
    @(negedge clk);
    chk("t3_nogrant0", 32'(invol_grant), 32'd0);
    do_burst(0, 32'h07, "t3_cmd_end");
    chk("t3_nogrant1", 32'(invol_grant), 32'd0);
    cmd_active = 0;
    wait_grant(4'b0100, "t3_grant2");
    invol_req = '0;
    do_burst(2, 32'h08, "t3_inv_end");

    // 4: unit 3 granted but silent -> timeout after TO cycles, unit 0 next
    invol_req = 4'b1001;
    wait_grant(4'b1000, "t4_grant3");
    cnt = 0;
    while (invol_grant[3] && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
    chk("t4_grant_cycles", 32'(cnt), 32'(TO));
    chk("t4_terr", 32'(timeout_err), 32'd1);
    wait_grant(4'b0001, "t4_grant0");
    invol_req = '0;
    do_burst(0, 32'h09, "t4_end");

    // 5: out_full blocks new grants but never stalls a burst
    out_full = 1; invol_req = 4'b0010;
    repeat (5) @(negedge clk);
    chk("t5_blocked", 32'(invol_grant), 32'd0);
    out_full = 0;
    wait_grant(4'b0010, "t5_grant1");
    invol_req = '0;
    wr(1, 1'b1, 32'hAB);
    @(negedge clk);
    out_full = 1; wr(1, 1'b1, 32'hCD);
    @(negedge clk);
    chk("t5_word", out_data, 32'hCD);
    wr(1, 1'b0, 32'h0E);
    @(negedge clk);
    chk("t5_end", 32'(out_end), 32'd1); chk("t5_code", out_data, 32'h0E);
    wr(1, 1'b0, '0); out_full = 0;

    // 6: asynchronous reset mid-burst
    invol_req = 4'b0100;
    wait_grant(4'b0100, "t6_grant2");
    invol_req = '0;
    wr(2, 1'b1, 32'h61);
    @(negedge clk);
    wr(2, 1'b1, 32'h62);
    @(posedge clk); #2;
    chk("t6_pre", 32'(out_write), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_async_out", {30'd0, out_write, out_end}, 32'd0);
    chk("t6_async_grant", 32'(invol_grant), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0; wr(2, 1'b0, '0);
`ifdef PARAM_ARB_STATS_EN
    chk("t6_stat0", stat_bursts, 32'd0);
`endif
    invol_req = 4'hF;
    wait_grant(4'b0001, "t6_grant0");
    invol_req = '0;
    do_burst(0, 32'h66, "t6_end");
    @(negedge clk);
`ifdef PARAM_ARB_STATS_EN
    chk("t6_stat1", stat_bursts, 32'd1);
`endif

    // random traffic, checked every cycle by the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(7) == 0) cmd_active = ~cmd_active;
      if ($urandom_range(3) == 0) cmd_unit = 2'($urandom_range(N - 1));
      for (int u = 0; u < N; u++) begin
        if ($urandom_range(7) == 0) invol_req[u] = ~invol_req[u];
        if ($urandom_range(3) == 0) unit_write[u] = ~unit_write[u];
        unit_data[32*u +: 32] = $urandom;
      end
      out_full = ($urandom_range(3) == 0);
    end
    cmd_active = 0; invol_req = '0; unit_write = '0; out_full = 0;
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
